// File: rtl/encoder_pkg.sv
// Shared types, defaults and step-decode helpers for the quadrature encoder datapath.
package encoder_pkg;

    localparam int unsigned ENC_W          = 32;
    localparam int unsigned DEFAULT_BIAS   = 1048;
    localparam int unsigned DEFAULT_PERIOD = 50_000;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC,
        STEP_ERR
    } enc_step_t;

    typedef logic signed [ENC_W-1:0] enc_count_t;

    // Classify a {A,B} transition; forward order is 00->10->11->01->00.
    function automatic enc_step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        enc_step_t s;
        s = STEP_NONE;
        if (prev == cur) begin
            s = STEP_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            s = STEP_ERR;
        end else begin
            case (prev)
                2'b00:   s = (cur == 2'b10) ? STEP_INC : STEP_DEC;
                2'b10:   s = (cur == 2'b11) ? STEP_INC : STEP_DEC;
                2'b11:   s = (cur == 2'b01) ? STEP_INC : STEP_DEC;
                default: s = (cur == 2'b00) ? STEP_INC : STEP_DEC;
            endcase
        end
        return s;
    endfunction

    // Signed accumulator increment for a decoded step; illegal steps count 0.
    function automatic enc_count_t step_to_inc(input enc_step_t s);
        enc_count_t v;
        case (s)
            STEP_INC: v = enc_count_t'(1);
            STEP_DEC: v = enc_count_t'(-1);
            default:  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// One encoder channel: 2-FF synchronizer, previous-state register and 4x decode.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   a, b         raw encoder phases, asynchronous to clk
//   step_c       decoded step for this cycle (combinational from prev/current state)
module quad_decoder
    import encoder_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      a,
    input  logic      b,
    output enc_step_t step_c
);

    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] prev;

    // Synchronize {A,B} and keep the previous synchronized state for edge decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            prev  <= 2'b00;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign step_c = decode_step(prev, sync2);

endmodule

// File: rtl/encoder_sample_ctrl.sv
// Encoder sampling controller: per-channel decode, windowed edge accumulation,
// biased result bank and a two-requester round-robin read port.
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   enable        window timer and accumulators run while high, cleared while low
//   enc_a, enc_b  raw encoder phases per channel
//   req, req_ch   read request and channel index per requester (CW bits each)
//   gnt           one-hot grant, combinational from req and the round-robin pointer
//   rd_valid      one-cycle pulse with rd_id / rd_data valid
//   sample_tick   one-cycle pulse after the result bank is updated
//   sample_seq    window counter, increments with sample_tick
//   err           sticky illegal-transition flag per channel
module encoder_sample_ctrl
    import encoder_pkg::*;
#(
    parameter  int unsigned N_ENC  = 2,
    parameter  int unsigned PERIOD = DEFAULT_PERIOD,
    parameter  int unsigned BIAS   = DEFAULT_BIAS,
    localparam int unsigned CW     = (N_ENC > 1) ? $clog2(N_ENC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_ENC-1:0]  enc_a,
    input  logic [N_ENC-1:0]  enc_b,
    input  logic [1:0]        req,
    input  logic [2*CW-1:0]   req_ch,
    output logic [1:0]        gnt,
    output logic              rd_valid,
    output logic              rd_id,
    output logic [ENC_W-1:0]  rd_data,
    output logic              sample_tick,
    output logic [15:0]       sample_seq,
    output logic [N_ENC-1:0]  err
);

    localparam int unsigned TW = $clog2(PERIOD);

    logic [TW-1:0]    timer;
    logic             window_end;
    enc_step_t        step [N_ENC];
    enc_count_t       inc [N_ENC];
    enc_count_t       acc [N_ENC];
    enc_count_t       result [N_ENC];
    logic             ptr;
    logic             grant_id;
    logic [CW-1:0]    grant_ch;
    logic [ENC_W-1:0] read_word;

    for (genvar g = 0; g < N_ENC; g++) begin : g_dec
        quad_decoder u_dec (
            .clk    (clk),
            .reset  (reset),
            .a      (enc_a[g]),
            .b      (enc_b[g]),
            .step_c (step[g])
        );
    end

    always_comb begin
        for (int i = 0; i < int'(N_ENC); i++) begin
            inc[i] = step_to_inc(step[i]);
        end
    end

    assign window_end = enable && (timer == TW'(PERIOD - 1));

    // Window timer; a low enable parks it at 0 so the next rise opens a full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!enable || window_end) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Accumulate and snapshot; the step decoded in the closing cycle joins that window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_ENC); i++) begin
                acc[i]    <= '0;
                result[i] <= ENC_W'(BIAS);
            end
        end else begin
            for (int i = 0; i < int'(N_ENC); i++) begin
                if (!enable || window_end) begin
                    acc[i] <= '0;
                end else begin
                    acc[i] <= acc[i] + inc[i];
                end
                if (window_end) begin
                    result[i] <= acc[i] + inc[i] + ENC_W'(BIAS);
                end
            end
        end
    end

    // Window sequencing and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_tick <= 1'b0;
            sample_seq  <= '0;
            err         <= '0;
        end else begin
            sample_tick <= window_end;
            if (window_end) begin
                sample_seq <= sample_seq + 16'd1;
            end
            for (int i = 0; i < int'(N_ENC); i++) begin
                if (step[i] == STEP_ERR) begin
                    err[i] <= 1'b1;
                end
            end
        end
    end

    // Round-robin grant: contention goes to the pointer owner.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

    assign grant_id = gnt[1];
    assign grant_ch = grant_id ? req_ch[CW +: CW] : req_ch[0 +: CW];

    // Out-of-range channel indices read back as all ones.
    always_comb begin
        read_word = '1;
        for (int i = 0; i < int'(N_ENC); i++) begin
            if (grant_ch == CW'(i)) begin
                read_word = result[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_id    <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= |gnt;
            if (|gnt) begin
                rd_id   <= grant_id;
                rd_data <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// Self-checking bench for encoder_sample_ctrl (N_ENC=3, PERIOD=100).
module tb_encoder_sample_ctrl;
    import encoder_pkg::*;

    localparam int unsigned N_ENC  = 3;
    localparam int unsigned PERIOD = 100;
    localparam int unsigned BIAS   = 1048;
    localparam int unsigned CW     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [N_ENC-1:0]  enc_a;
    logic [N_ENC-1:0]  enc_b;
    logic [1:0]        req;
    logic [2*CW-1:0]   req_ch;
    logic [1:0]        gnt;
    logic              rd_valid;
    logic              rd_id;
    logic [31:0]       rd_data;
    logic              sample_tick;
    logic [15:0]       sample_seq;
    logic [N_ENC-1:0]  err;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] sb_q[$];
    logic [31:0] exp_result [N_ENC];
    int          win_exp [N_ENC];
    logic [1:0]  pos [N_ENC];
    logic        tick_seen;
    int          k;

    encoder_sample_ctrl #(.N_ENC(N_ENC), .PERIOD(PERIOD), .BIAS(BIAS)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .req         (req),
        .req_ch      (req_ch),
        .gnt         (gnt),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_data     (rd_data),
        .sample_tick (sample_tick),
        .sample_seq  (sample_seq),
        .err         (err)
    );

    always #5 clk = ~clk;

    // One clock: log grants taken at the coming edge, then score the outputs after it.
    task automatic tick();
        logic [CW-1:0] ch;
        logic [32:0]   ent;
        #1;
        if (!reset) begin
            for (int r = 0; r < 2; r++) begin
                if (gnt[r]) begin
                    checks++;
                    if (req[r] !== 1'b1) begin
                        errors++;
                        $display("FAIL gnt_without_req r=%0d gnt=%b req=%b", r, gnt, req);
                    end
                    ch = req_ch[r*CW +: CW];
                    ent[32]   = r[0];
                    ent[31:0] = (int'(ch) < int'(N_ENC)) ? exp_result[int'(ch)] : 32'hFFFF_FFFF;
                    sb_q.push_back(ent);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        tick_seen = 1'b0;
        if (reset) begin
            sb_q.delete();
            for (int i = 0; i < int'(N_ENC); i++) exp_result[i] = 32'(BIAS);
        end else begin
            if (rd_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_valid_unexpected id=%0d data=%h expected no read", rd_id, rd_data);
                end else begin
                    ent = sb_q.pop_front();
                    if ({rd_id, rd_data} !== ent) begin
                        errors++;
                        $display("FAIL read_data got id=%0d data=%h expected id=%0d data=%h",
                                 rd_id, rd_data, ent[32], ent[31:0]);
                    end
                end
            end
            if (sample_tick) begin
                tick_seen = 1'b1;
                for (int i = 0; i < int'(N_ENC); i++) exp_result[i] = 32'(BIAS) + 32'(win_exp[i]);
            end
        end
    endtask

    task automatic drive_pos(input int ch, input logic [1:0] n);
        pos[ch]   = n;
        enc_a[ch] = n[1];
        enc_b[ch] = n[0];
    endtask

    task automatic step_ch(input int ch, input bit fwd);
        logic [1:0] p;
        logic [1:0] n;
        p = pos[ch];
        if (fwd) begin
            case (p)
                2'b00:   n = 2'b10;
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end else begin
            case (p)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                2'b11:   n = 2'b10;
                default: n = 2'b00;
            endcase
        end
        drive_pos(ch, n);
    endtask

    task automatic do_read(input int r, input int ch);
        req_ch[r*CW +: CW] = CW'(ch);
        req[r] = 1'b1;
        tick();
        req[r] = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL read_missing r=%0d ch=%0d pending=%0d expected 0", r, ch, sb_q.size());
            sb_q.delete();
        end
    endtask

    // First tick is visible in the cycle after the PERIOD-th enabled edge.
    task automatic check_window(input string name, input int got);
        checks++;
        if (!tick_seen || got != int'(PERIOD)) begin
            errors++;
            $display("FAIL %s window_len got=%0d seen=%0d expected %0d", name, got, tick_seen, PERIOD);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; req = 2'b11; req_ch = '0;
        for (int i = 0; i < int'(N_ENC); i++) drive_pos(i, 2'b00);
        win_exp = '{0, 0, 0};
        tick();
        checks++;
        if ({rd_valid, rd_id, rd_data, sample_tick} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b id=%b d=%h t=%b expected zeros", rd_valid, rd_id, rd_data, sample_tick);
        end
        checks++;
        if (sample_seq !== 16'd0 || err !== '0) begin
            errors++;
            $display("FAIL reset_seq_err got seq=%h err=%b expected 0", sample_seq, err);
        end
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_gnt got %b expected 01", gnt);
        end
        req = 2'b00;
        reset = 1'b0;
        tick();
        do_read(0, 0);
        do_read(1, 2);
    endtask

    task automatic test_forward();
        win_exp = '{40, 0, 0};
        enable = 1'b1;
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
            if (k % 2 == 1 && k < 80) step_ch(0, 1'b1);
        end
        check_window("forward", k);
        checks++;
        if (sample_seq !== 16'd1) begin
            errors++;
            $display("FAIL forward_seq got %0d expected 1", sample_seq);
        end
        enable = 1'b0;
        do_read(0, 0);
        do_read(1, 1);
    endtask

    task automatic test_reverse();
        win_exp = '{0, -10, 0};
        enable = 1'b1;
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
            if (k % 2 == 1 && k < 20) step_ch(1, 1'b0);
        end
        check_window("reverse", k);
        checks++;
        if (sample_seq !== 16'd2) begin
            errors++;
            $display("FAIL reverse_seq got %0d expected 2", sample_seq);
        end
        enable = 1'b0;
        do_read(1, 1);
        do_read(0, 0);
        // Jump the window counter to its last value to exercise the wrap.
        force dut.sample_seq = 16'hFFFF;
        tick();
        release dut.sample_seq;
        win_exp = '{0, 0, 0};
        enable = 1'b1;
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
        end
        check_window("wrap", k);
        checks++;
        if (sample_seq !== 16'd0) begin
            errors++;
            $display("FAIL seq_wrap got %h expected 0000", sample_seq);
        end
        enable = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_gnt;
        req_ch = {2'd1, 2'd0};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL arb_gnt cycle=%0d got %b expected %b", i, gnt, exp_gnt);
            end
            tick();
        end
        req = 2'b00;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL arb_reads pending=%0d expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_boundary();
        win_exp = '{1, 0, 0};
        enable = 1'b1;
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
            if (k == int'(PERIOD) - 3) step_ch(0, 1'b1);
            if (k == int'(PERIOD) - 2) step_ch(1, 1'b1);
            if (k == int'(PERIOD) - 1) begin req_ch[0 +: CW] = 2'd0; req[0] = 1'b1; end
            if (k == int'(PERIOD)) req[0] = 1'b0;
        end
        req[0] = 1'b0;
        check_window("boundary_w1", k);
        // ch1 step decoded right after the snapshot belongs to the next window.
        win_exp = '{0, 1, 0};
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
            if (k == 1) begin req_ch[0 +: CW] = 2'd0; req[0] = 1'b1; end
            if (k == 2) req[0] = 1'b0;
        end
        req[0] = 1'b0;
        check_window("boundary_w2", k);
        enable = 1'b0;
        do_read(1, 1);
        do_read(0, 0);
    endtask

    task automatic test_illegal();
        win_exp = '{0, 0, 0};
        enable = 1'b1;
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
            if (k == 5 || k == 10) drive_pos(0, pos[0] ^ 2'b11);
        end
        check_window("illegal", k);
        checks++;
        if (err !== 3'b001) begin
            errors++;
            $display("FAIL err_set got %b expected 001", err);
        end
        enable = 1'b0;
        do_read(0, 0);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err !== 3'b001) begin
            errors++;
            $display("FAIL err_sticky got %b expected 001", err);
        end
        do_read(1, 3);
    endtask

    task automatic test_reset_mid();
        win_exp = '{7, 7, 7};
        enable = 1'b1;
        for (int ch = 0; ch < int'(N_ENC); ch++) begin
            for (int s = 0; s < 3 && pos[ch] != 2'b00; s++) begin
                step_ch(ch, 1'b1);
                tick();
            end
        end
        for (int i = 0; i < 20; i++) tick();
        req_ch[0 +: CW] = 2'd0;
        req[0] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || sample_seq !== 16'd0 || err !== '0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_now got v=%b seq=%h err=%b d=%h expected 0", rd_valid, sample_seq, err, rd_data);
        end
        tick();
        req[0] = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_valid got %b expected 0", rd_valid);
        end
        win_exp = '{0, 0, 0};
        reset = 1'b0;
        k = 0; tick_seen = 1'b0;
        while (!tick_seen && k < 3 * int'(PERIOD)) begin
            tick(); k++;
        end
        check_window("after_reset", k);
        enable = 1'b0;
        do_read(0, 0);
        do_read(1, 1);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_arbitration();
        test_boundary();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
